// File: rtl/led_pwm_rmap_if.sv
// Local bus bundle for led_pwm_rmap: byte-strobed write channel plus a
// one-cycle-latency read request/response pair.
interface led_pwm_rmap_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int STRB_W = DATA_W/8
);
    logic [ADDR_W-1:0] lb_waddr;
    logic [DATA_W-1:0] lb_wdata;
    logic              lb_wen;
    logic [STRB_W-1:0] lb_wstrb;
    logic              lb_wready;
    logic [ADDR_W-1:0] lb_raddr;
    logic              lb_ren;
    logic [DATA_W-1:0] lb_rdata;
    logic              lb_rvalid;

    modport master (
        output lb_waddr, lb_wdata, lb_wen, lb_wstrb, lb_raddr, lb_ren,
        input  lb_wready, lb_rdata, lb_rvalid
    );

    modport slave (
        input  lb_waddr, lb_wdata, lb_wen, lb_wstrb, lb_raddr, lb_ren,
        output lb_wready, lb_rdata, lb_rvalid
    );
endinterface

// File: rtl/led_pwm_rmap.sv
// Register-mapped multi-channel LED PWM with shadowed duty cycles.
// Define LED_PWM_RMAP_IRQ_EN to build the STATUS.PEND / CTRL.IRQ_EN / irq logic.
module led_pwm_rmap #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int STRB_W = DATA_W/8,
    parameter int CH_N   = 3,
    parameter int PWM_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    led_pwm_rmap_if.slave   lb,
    output logic [CH_N-1:0] pwm_out,
    output logic            irq
);
    localparam logic [DATA_W-1:0] IDLE_WORD = DATA_W'(16'hDEAD);

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] wset;
    logic              wr_ctrl;
    logic              wr_period;
    logic [CH_N-1:0]   wr_duty;
    logic              en;
    logic              irq_en;
    logic              pend;
    logic              wrap;
    logic [PWM_W-1:0]  period;
    logic [PWM_W-1:0]  cnt;
    logic [PWM_W-1:0]  duty   [CH_N];
    logic [PWM_W-1:0]  shadow [CH_N];
    logic [DATA_W-1:0] rd_word;

    // Reset asserts asynchronously but releases two clock edges later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= '0;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    function automatic logic [PWM_W-1:0] merge_field(
        input logic [PWM_W-1:0]  old,
        input logic [DATA_W-1:0] mask,
        input logic [DATA_W-1:0] set
    );
        return PWM_W'((DATA_W'(old) & ~mask) | set);
    endfunction

    always_comb begin
        wmask = '0;
        for (int b = 0; b < STRB_W; b++)
            wmask[8*b +: 8] = {8{lb.lb_wstrb[b]}};
        wset      = lb.lb_wdata & wmask;
        wr_ctrl   = lb.lb_wen && (lb.lb_waddr == ADDR_W'(0));
        wr_period = lb.lb_wen && (lb.lb_waddr == ADDR_W'(2));
        for (int i = 0; i < CH_N; i++)
            wr_duty[i] = lb.lb_wen && (lb.lb_waddr == ADDR_W'(16 + 2*i));
    end

    assign lb.lb_wready = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en     <= 1'b0;
            period <= '1;
            for (int i = 0; i < CH_N; i++) duty[i] <= '0;
        end else begin
            if (wr_ctrl && lb.lb_wstrb[0]) en <= lb.lb_wdata[0];
            if (wr_period) period <= merge_field(period, wmask, wset);
            for (int i = 0; i < CH_N; i++)
                if (wr_duty[i]) duty[i] <= merge_field(duty[i], wmask, wset);
        end
    end

    // A PERIOD written below cnt is not a wrap; cnt then runs on to all-ones.
    assign wrap = en && (cnt == period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pwm_out <= '0;
            for (int i = 0; i < CH_N; i++) shadow[i] <= '0;
        end else begin
            if (!en || wrap) cnt <= '0;
            else             cnt <= cnt + PWM_W'(1);
            for (int i = 0; i < CH_N; i++) begin
                if (!en || wrap) shadow[i] <= duty[i];
                pwm_out[i] <= en && (cnt < shadow[i]);
            end
        end
    end

`ifdef LED_PWM_RMAP_IRQ_EN
    logic wr_status;
    assign wr_status = lb.lb_wen && (lb.lb_waddr == ADDR_W'(4));

    // A wrap in the same cycle as the W1C wins, so no period end is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            pend   <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_ctrl && lb.lb_wstrb[0]) irq_en <= lb.lb_wdata[1];
            if (wrap)
                pend <= 1'b1;
            else if (wr_status && lb.lb_wstrb[0] && lb.lb_wdata[0])
                pend <= 1'b0;
            irq <= pend && irq_en;
        end
    end
`else
    assign irq_en = 1'b0;
    assign pend   = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rd_word = IDLE_WORD;
        if (lb.lb_raddr == ADDR_W'(0)) rd_word = DATA_W'({irq_en, en});
        if (lb.lb_raddr == ADDR_W'(2)) rd_word = DATA_W'(period);
        if (lb.lb_raddr == ADDR_W'(4)) rd_word = DATA_W'(pend);
        for (int i = 0; i < CH_N; i++)
            if (lb.lb_raddr == ADDR_W'(16 + 2*i)) rd_word = DATA_W'(duty[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb.lb_rvalid <= 1'b0;
            lb.lb_rdata  <= IDLE_WORD;
        end else begin
            lb.lb_rvalid <= lb.lb_ren;
            lb.lb_rdata  <= lb.lb_ren ? rd_word : IDLE_WORD;
        end
    end
endmodule
